// File: rtl/prbs_pkg.sv
// Shared types and defaults for the prbs8 measurement controller.
package prbs_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOLD = 3'd1,
    CAPT = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } ctrl_state_t;

  localparam int unsigned PRBS_W        = 8;
  localparam int unsigned PRBS_MAX_CNT  = 256;
  localparam logic [7:0]  PRBS_MASK_RST = 8'hE1;

endpackage

// File: rtl/prbs8_period_ctrl.sv
// Sequencer/measurement controller for one prbs8 generator: holds it in reset,
// releases it, counts clocks until its state recurs, optionally sweeping masks.
module prbs8_period_ctrl
  import prbs_pkg::*;
#(
  parameter int unsigned W       = PRBS_W,
  parameter int unsigned RST_CYC = 2,
  parameter int unsigned MAX_CNT = PRBS_MAX_CNT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sweep,
  input  logic [W-1:0] mask_in,
  input  logic [W-1:0] prbs_state,
  output logic         prbs_rst,
  output logic [W-1:0] prbs_mask,
  output logic         busy,
  output logic         done,
  output logic [8:0]   period,
  output logic         maximal,
  output logic         timeout
);

  localparam int unsigned HW        = (RST_CYC < 2) ? 1 : $clog2(RST_CYC);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYC - 1);
  localparam logic [8:0]  CNT_MAX   = 9'(MAX_CNT);
  localparam logic [8:0]  PER_MAX   = 9'((1 << W) - 1);

  ctrl_state_t   state, state_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic [8:0]    cnt, cnt_d;
  logic [W-1:0]  ref_state, ref_d;
  logic [W-1:0]  mask_d;
  logic          sweep_q, sweep_d;
  logic          busy_d, done_d, maximal_d, timeout_d;
  logic [8:0]    period_d;
  logic          hit, tmo, res_max;

  // Generator runs only while capturing its seed and during the count.
  assign prbs_rst = !(state == CAPT || state == RUN);

  assign hit     = (prbs_state == ref_state);
  assign tmo     = !hit && (cnt == CNT_MAX);
  assign res_max = hit && (cnt == PER_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      cnt       <= '0;
      ref_state <= '0;
      prbs_mask <= W'(PRBS_MASK_RST);
      sweep_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      period    <= '0;
      maximal   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_d;
      hold_cnt  <= hold_d;
      cnt       <= cnt_d;
      ref_state <= ref_d;
      prbs_mask <= mask_d;
      sweep_q   <= sweep_d;
      busy      <= busy_d;
      done      <= done_d;
      period    <= period_d;
      maximal   <= maximal_d;
      timeout   <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state;
    hold_d    = hold_cnt;
    cnt_d     = cnt;
    ref_d     = ref_state;
    mask_d    = prbs_mask;
    sweep_d   = sweep_q;
    busy_d    = busy;
    done_d    = done;
    period_d  = period;
    maximal_d = maximal;
    timeout_d = timeout;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          mask_d    = mask_in;
          sweep_d   = sweep;
          done_d    = 1'b0;
          period_d  = '0;
          maximal_d = 1'b0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          hold_d    = '0;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) state_d = CAPT;
        else                       hold_d  = hold_cnt + 1'b1;
      end
      CAPT: begin
        ref_d   = prbs_state;
        cnt_d   = 9'd1;
        state_d = RUN;
      end
      RUN: begin
        if (hit || tmo) begin
          period_d  = hit ? cnt : '0;
          timeout_d = tmo;
          // Sweep continues with the next mask unless maximal or mask is saturated.
          if (sweep_q && !res_max && (prbs_mask != '1)) begin
            mask_d    = prbs_mask + 1'b1;
            timeout_d = 1'b0;
            hold_d    = '0;
            state_d   = HOLD;
          end else begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            maximal_d = res_max;
            state_d   = DONE;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
